// File: rtl/fft_serializer.sv
// Serializes one 8-word complex FFT result frame into 16-bit beats with valid/ready on both
// sides, optional bit-reversed word order and a real-only emit mode.
module fft_serializer #(
    parameter int unsigned INPUT_SIZE  = 256,
    parameter int unsigned OUTPUT_SIZE = 16,
    parameter int unsigned WORD_SIZE   = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   input_valid,
    output logic                   input_ready,
    input  logic                   bit_reverse,
    input  logic                   real_only,
    input  logic [INPUT_SIZE-1:0]  in,
    input  logic                   output_ready,
    output logic                   output_valid,
    output logic [OUTPUT_SIZE-1:0] out,
    output logic                   last
);

    localparam int unsigned NumWords = INPUT_SIZE / WORD_SIZE;

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e                  state_q, state_d;
    logic [INPUT_SIZE-1:0]   frame_q, frame_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    rev_q, rev_d;
    logic                    real_q, real_d;

    logic [WORD_SIZE-1:0]    words [NumWords];
    logic [WORD_SIZE-1:0]    word_sel;
    logic [2:0]              idx;
    logic [2:0]              widx;
    logic                    imag_sel;
    logic                    in_acc;
    logic                    beat;

    for (genvar k = 0; k < NumWords; k++) begin : g_words
        assign words[k] = frame_q[k*WORD_SIZE +: WORD_SIZE];
    end

    // Outputs depend only on registered state, so they hold steady through a stall.
    always_comb begin
        idx          = real_q ? cnt_q[2:0] : cnt_q[3:1];
        widx         = rev_q ? {idx[0], idx[1], idx[2]} : idx;
        imag_sel     = !real_q && cnt_q[0];
        word_sel     = words[widx];
        output_valid = (state_q == StSend);
        out          = '0;
        if (output_valid) begin
            out = imag_sel ? word_sel[OUTPUT_SIZE-1:0]
                           : word_sel[WORD_SIZE-1:WORD_SIZE-OUTPUT_SIZE];
        end
        last        = output_valid && (cnt_q == (real_q ? 4'd7 : 4'd15));
        input_ready = (state_q == StIdle) || (last && output_ready);
        in_acc      = input_valid && input_ready;
        beat        = output_valid && output_ready;
    end

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        cnt_d   = cnt_q;
        rev_d   = rev_q;
        real_d  = real_q;
        if (in_acc) begin
            // Covers both the idle accept and the back-to-back reload on the final beat.
            frame_d = in;
            rev_d   = bit_reverse;
            real_d  = real_only;
            cnt_d   = '0;
            state_d = StSend;
        end else if (beat) begin
            if (last) begin
                cnt_d   = '0;
                state_d = StIdle;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            frame_q <= '0;
            cnt_q   <= '0;
            rev_q   <= 1'b0;
            real_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            cnt_q   <= cnt_d;
            rev_q   <= rev_d;
            real_q  <= real_d;
        end
    end

endmodule

// File: tb/tb_fft_serializer.sv
// Directed bench for fft_serializer: ordering modes, backpressure, back-to-back frames and
// mid-frame reset, with expected beats computed from a hand-written word-order table.
module tb_fft_serializer;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         input_valid;
    logic         input_ready;
    logic         bit_reverse;
    logic         real_only;
    logic [255:0] in;
    logic         output_ready;
    logic         output_valid;
    logic [15:0]  out;
    logic         last;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fft_serializer #(
        .INPUT_SIZE (256),
        .OUTPUT_SIZE(16),
        .WORD_SIZE  (32)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .input_valid (input_valid),
        .input_ready (input_ready),
        .bit_reverse (bit_reverse),
        .real_only   (real_only),
        .in          (in),
        .output_ready(output_ready),
        .output_valid(output_valid),
        .out         (out),
        .last        (last)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Word k = {k, re, k, im} with 4-bit k in the top nibble of each half.
    function automatic logic [255:0] make_frame(input logic [11:0] re, input logic [11:0] im);
        logic [255:0] f;
        logic [3:0]   kn;
        f = '0;
        for (int k = 0; k < 8; k++) begin
            kn = 4'(k);
            f[32*k +: 32] = {kn, re, kn, im};
        end
        return f;
    endfunction

    function automatic logic [15:0] exp_beat(input int c, input logic rev, input logic ro,
                                             input logic [11:0] re, input logic [11:0] im);
        int         i;
        logic [3:0] w;
        i = ro ? c : c / 2;
        if (rev) begin
            case (i)
                1: i = 4;
                2: i = 2;
                3: i = 6;
                4: i = 1;
                5: i = 5;
                6: i = 3;
                7: i = 7;
                default: i = 0;
            endcase
        end
        w = 4'(i);
        if (!ro && (c % 2 == 1)) return {w, im};
        return {w, re};
    endfunction

    task automatic offer(input logic [255:0] f, input logic rev, input logic ro);
        @(negedge clk);
        in          = f;
        bit_reverse = rev;
        real_only   = ro;
        input_valid = 1'b1;
        #1;
        check("offer_ready", input_ready, 1);
        @(posedge clk);
        #1;
        // Scramble everything after the accept; none of it may leak into the frame.
        input_valid = 1'b0;
        in          = ~f;
        bit_reverse = ~rev;
        real_only   = ~ro;
    endtask

    task automatic drain(input logic rev, input logic ro, input logic [11:0] re,
                         input logic [11:0] im, input bit bp, input int stop_at,
                         input bit chain, input logic [255:0] nf, input logic nrev,
                         input logic nro);
        int n;
        int limit;
        int beats;
        int cyc;
        int hold;
        n     = ro ? 8 : 16;
        limit = (stop_at < n) ? stop_at : n;
        beats = 0;
        cyc   = 0;
        hold  = 0;
        while (beats < limit && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (bp) begin
                if (beats == 5 && hold < 5) begin
                    output_ready = 1'b0;
                    hold++;
                end else begin
                    output_ready = 1'($urandom_range(0, 1));
                end
            end else begin
                output_ready = 1'b1;
            end
            if (chain && beats == n - 1) begin
                in          = nf;
                bit_reverse = nrev;
                real_only   = nro;
                input_valid = 1'b1;
            end
            #1;
            check("valid", output_valid, 1);
            check("out", out, exp_beat(beats, rev, ro, re, im));
            check("last", last, beats == n - 1);
            check("in_ready", input_ready, (beats == n - 1) && output_ready);
            @(posedge clk);
            if (output_ready) beats++;
            #1;
            if (chain && beats == n) begin
                input_valid = 1'b0;
                in          = ~nf;
                bit_reverse = ~nrev;
                real_only   = ~nro;
            end
        end
        check("beat_count", beats, limit);
    endtask

    task automatic expect_idle(input string tag);
        @(negedge clk);
        output_ready = 1'b1;
        #1;
        check({tag, "_valid"}, output_valid, 0);
        check({tag, "_last"}, last, 0);
        check({tag, "_ready"}, input_ready, 1);
    endtask

    logic [255:0] fa;
    logic [255:0] fb;

    initial begin
        fa           = make_frame(12'h0A0, 12'h0B0);
        fb           = make_frame(12'h0C0, 12'h0D0);
        reset_n      = 1'b0;
        input_valid  = 1'b0;
        bit_reverse  = 1'b0;
        real_only    = 1'b0;
        in           = '0;
        output_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst_valid", output_valid, 0);
        check("rst_last", last, 0);
        check("rst_out", out, 0);
        check("rst_ready", input_ready, 1);

        // Plain complex frame
        offer(fa, 1'b0, 1'b0);
        drain(1'b0, 1'b0, 12'h0A0, 12'h0B0, 1'b0, 99, 1'b0, '0, 1'b0, 1'b0);
        expect_idle("idle1");

        // Bit-reversed order
        offer(fa, 1'b1, 1'b0);
        drain(1'b1, 1'b0, 12'h0A0, 12'h0B0, 1'b0, 99, 1'b0, '0, 1'b0, 1'b0);
        expect_idle("idle2");

        // Real-only
        offer(fa, 1'b0, 1'b1);
        drain(1'b0, 1'b1, 12'h0A0, 12'h0B0, 1'b0, 99, 1'b0, '0, 1'b0, 1'b0);
        expect_idle("idle3");

        // Random backpressure with a 5-cycle hold
        offer(fa, 1'b0, 1'b0);
        drain(1'b0, 1'b0, 12'h0A0, 12'h0B0, 1'b1, 99, 1'b0, '0, 1'b0, 1'b0);
        expect_idle("idle4");

        // Back-to-back: A complex/natural, then B real-only/bit-reversed with no gap
        offer(fa, 1'b0, 1'b0);
        drain(1'b0, 1'b0, 12'h0A0, 12'h0B0, 1'b0, 99, 1'b1, fb, 1'b1, 1'b1);
        drain(1'b1, 1'b1, 12'h0C0, 12'h0D0, 1'b0, 99, 1'b0, '0, 1'b0, 1'b0);
        expect_idle("idle5");

        // Mid-frame reset after 6 beats
        offer(fb, 1'b0, 1'b0);
        drain(1'b0, 1'b0, 12'h0C0, 12'h0D0, 1'b0, 6, 1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("mrst_valid", output_valid, 0);
        check("mrst_ready", input_ready, 1);
        check("mrst_out", out, 0);
        check("mrst_last", last, 0);
        offer(fa, 1'b0, 1'b0);
        drain(1'b0, 1'b0, 12'h0A0, 12'h0B0, 1'b0, 99, 1'b0, '0, 1'b0, 1'b0);
        expect_idle("idle6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_serializer.md
Name: fft_serializer

Overview:
- Converts one parallel FFT result frame (8 complex words, 256 bits) into a serial stream of 16-bit beats for the output interface.
- Sits directly downstream of the 8-point FFT core. It mirrors the deserializer frame layout at the FFT input.
- Adds a valid/ready handshake on both sides, optional bit-reversed word ordering and a real-only emit mode.

Parameters:
- INPUT_SIZE, 256, bit width of the parallel input frame.
- OUTPUT_SIZE, 16, bit width of each serial output beat (equals WORD_SIZE/2).
- WORD_SIZE, 32, bits per complex word: real in the upper half, imaginary in the lower half.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- reset_n  input  1  synchronous, active-low reset.
- input_valid  input  1  `in` holds a complete frame.
- input_ready  output  1  block can accept a frame this cycle.
- bit_reverse  input  1  sampled with the frame; 1 = emit words in bit-reversed index order.
- real_only  input  1  sampled with the frame; 1 = emit real halves only.
- in  input  INPUT_SIZE  frame; word k occupies in[32k+31:32k], real part in [32k+31:32k+16].
- output_ready  input  1  downstream accepts the beat this cycle.
- output_valid  output  1  `out` holds a valid beat.
- out  output  OUTPUT_SIZE  serial beat.
- last  output  1  high with the final beat of a frame.

Behaviour:
- Reset:
  - Applies while reset_n is low at a rising edge, regardless of state. Any frame in progress is discarded.
  - After reset: state IDLE, output_valid=0, last=0, out=0, beat counter=0, frame register=0, latched modes=0.
  - input_ready=1 from the first cycle after reset release.
- Transfer rules:
  - Input accept: input_valid && input_ready at a rising edge.
  - Output beat: output_valid && output_ready at a rising edge.
- State IDLE:
  - input_ready=1, output_valid=0.
  - On input accept: latch `in`, bit_reverse and real_only; counter=0; go to SEND.
  - output_valid=1 in the next cycle, so first-beat latency is one cycle.
- State SEND:
  - output_valid=1.
  - out and last are driven from registered state only. They stay stable while output_valid && !output_ready.
- Beat mapping, complex mode:
  - 16 beats; counter c runs 0..15.
  - Word index w = c[3:1], or bitrev3(c[3:1]) when bit_reverse is latched.
  - c[0]=0 emits real, in[32w+31:32w+16]; c[0]=1 emits imaginary, in[32w+15:32w].
- Beat mapping, real_only mode:
  - 8 beats; c runs 0..7.
  - w = c, or bitrev3(c) when bit_reverse is latched. Real half only.
- Counter advance: increments only on an output beat. No beat, no change.
- last=1 when c equals the final index: 15 in complex mode, 7 in real_only mode.
- input_ready in SEND = last && output_ready (combinational). It is 0 otherwise.
- On the final beat:
  - Input accept in the same cycle: load the new frame and modes, c=0, stay in SEND. This gives back-to-back frames with no bubble.
  - Otherwise: go to IDLE; output_valid=0 next cycle.
- Mode and data isolation:
  - bit_reverse, real_only and `in` are ignored except at an input accept.
  - Changes to them mid-frame have no effect.
- Edge cases:
  - input_valid while busy is not accepted; the upstream side holds the frame.
  - output_ready held low stalls indefinitely with no beat loss or duplication.
- Throughput: one beat per cycle while output_ready=1; 16 cycles per complex frame, 8 per real_only frame.

Test Plan:
- Frame accept and first beat:
  - Stimulus: reset, then accept a frame where word k = {16'h(k)0A0, 16'h(k)0B0}, bit_reverse=0, real_only=0, output_ready=1.
  - Required: beats 0x00A0, 0x00B0, 0x10A0, 0x10B0, ... 0x70A0, 0x70B0; last only on beat 16; input_ready=0 until the last beat.
- Bit reversal:
  - Stimulus: same frame, bit_reverse=1.
  - Required: real beats in word order 0,4,2,6,1,5,3,7, e.g. beat 2 = 0x40A0, beat 3 = 0x40B0.
- Real_only mode:
  - Stimulus: same frame, real_only=1.
  - Required: 8 beats 0x00A0..0x70A0; last on beat 8; no imaginary beats.
- Backpressure:
  - Stimulus: toggle output_ready randomly, including a 5-cycle low hold.
  - Required: out and last stable while stalled; exactly 16 beats in order; counter unchanged during stalls.
- Back-to-back frames:
  - Stimulus: input_valid held high with frame B presented on the last beat of frame A.
  - Required: B accepted that cycle; B's first beat in the next cycle with no output_valid gap.
  - Required: modes switch from A's to B's exactly at the frame boundary.
- Mid-frame reset:
  - Stimulus: assert reset_n=0 at beat 6 of a frame.
  - Required: output_valid=0 and input_ready=1 after release; the next accepted frame starts at word 0 real.
